// File: rtl/target_pkg.sv
// Shared types and helpers for the windowed memory target.
package target_pkg;

   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WDATA,
      RD_WAIT,
      WR_WAIT
   } target_state_e;

   // True when addr falls in the window of base; only bits above 'bits' are compared.
   function automatic logic win_hit(input logic [ADDR_W-1:0] addr,
                                    input logic [ADDR_W-1:0] base,
                                    input int bits);
      logic [ADDR_W-1:0] diff;
      diff = addr ^ base;
      return ((diff >> bits) == '0);
   endfunction

endpackage

// File: rtl/target_mem_array.sv
// Word-addressed storage: synchronous write port, combinational read port, no reset.
module target_mem_array #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_BITS  = 8
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_BITS-1:0]  waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_BITS-1:0]  raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_BITS];

   // Commit one word per clock when the controller asks for it.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/target_mem_ws.sv
// Memory-mapped bus target with window decode, programmable read/write wait
// states and a write-data timeout. Ready is high only while idle.
module target_mem_ws
   import target_pkg::*;
#(
   parameter int                DATA_WIDTH         = 8,
   parameter int                INTERNAL_ADDR_BITS = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR          = 16'h0000,
   parameter int                READ_LATENCY       = 0,
   parameter int                WRITE_LATENCY      = 0,
   parameter int                WDATA_TIMEOUT      = 15
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_W-1:0]     target_addr_in,
   input  logic                  target_addr_in_valid,
   input  logic [DATA_WIDTH-1:0] target_data_in,
   input  logic                  target_data_in_valid,
   input  logic                  target_rw,
   output logic [DATA_WIDTH-1:0] target_data_out,
   output logic                  target_data_out_valid,
   output logic                  target_ack,
   output logic                  target_err,
   output logic                  target_ready
);

   localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int MAX_CNT = (MAX_LAT > WDATA_TIMEOUT) ? MAX_LAT : WDATA_TIMEOUT;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   // Counter reload values: the wait states count down to zero, the response
   // happens on the edge that sees zero.
   localparam logic [CNT_W-1:0] RD_LOAD  = CNT_W'((READ_LATENCY  > 0) ? READ_LATENCY  - 1 : 0);
   localparam logic [CNT_W-1:0] WR_LOAD  = CNT_W'((WRITE_LATENCY > 0) ? WRITE_LATENCY - 1 : 0);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(WDATA_TIMEOUT - 1);

   target_state_e state;
   target_state_e state_next;

   logic [CNT_W-1:0]              cnt;
   logic [CNT_W-1:0]              cnt_next;
   logic [INTERNAL_ADDR_BITS-1:0] idx_q;
   logic [INTERNAL_ADDR_BITS-1:0] idx_next;
   logic [DATA_WIDTH-1:0]         wdata_q;
   logic [DATA_WIDTH-1:0]         wdata_next;

   logic [DATA_WIDTH-1:0]         dout_next;
   logic                          dov_next;
   logic                          ack_next;
   logic                          err_next;

   logic                          mem_we;
   logic [INTERNAL_ADDR_BITS-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0]         mem_wdata;
   logic [INTERNAL_ADDR_BITS-1:0] mem_raddr;
   logic [DATA_WIDTH-1:0]         mem_rdata;

   logic                          hit;
   logic [INTERNAL_ADDR_BITS-1:0] addr_idx;

   assign hit          = win_hit(target_addr_in, BASE_ADDR, INTERNAL_ADDR_BITS);
   assign addr_idx     = target_addr_in[INTERNAL_ADDR_BITS-1:0];
   assign target_ready = (state == IDLE);

   target_mem_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_BITS  (INTERNAL_ADDR_BITS)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we & rst_n),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .raddr (mem_raddr),
      .rdata (mem_rdata)
   );

   // Next-state, counter, latch and response decisions for the current cycle.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx_q;
      wdata_next = wdata_q;
      dout_next  = target_data_out;
      dov_next   = 1'b0;
      ack_next   = 1'b0;
      err_next   = 1'b0;
      mem_we     = 1'b0;
      mem_waddr  = idx_q;
      mem_wdata  = wdata_q;
      mem_raddr  = idx_q;

      case (state)
         IDLE: begin
            mem_raddr = addr_idx;
            mem_waddr = addr_idx;
            mem_wdata = target_data_in;
            if (target_addr_in_valid && hit) begin
               idx_next = addr_idx;
               if (!target_rw) begin
                  if (READ_LATENCY == 0) begin
                     dout_next = mem_rdata;
                     dov_next  = 1'b1;
                     ack_next  = 1'b1;
                  end else begin
                     state_next = RD_WAIT;
                     cnt_next   = RD_LOAD;
                  end
               end else if (target_data_in_valid) begin
                  wdata_next = target_data_in;
                  if (WRITE_LATENCY == 0) begin
                     mem_we   = 1'b1;
                     ack_next = 1'b1;
                  end else begin
                     state_next = WR_WAIT;
                     cnt_next   = WR_LOAD;
                  end
               end else begin
                  state_next = WAIT_WDATA;
                  cnt_next   = '0;
               end
            end
         end

         WAIT_WDATA: begin
            mem_wdata = target_data_in;
            if (target_data_in_valid) begin
               wdata_next = target_data_in;
               if (WRITE_LATENCY == 0) begin
                  mem_we     = 1'b1;
                  ack_next   = 1'b1;
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  state_next = WR_WAIT;
                  cnt_next   = WR_LOAD;
               end
            end else if (cnt == TMO_LAST) begin
               err_next   = 1'b1;
               state_next = IDLE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         RD_WAIT: begin
            if (cnt == '0) begin
               dout_next  = mem_rdata;
               dov_next   = 1'b1;
               ack_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end

         WR_WAIT: begin
            if (cnt == '0) begin
               mem_we     = 1'b1;
               ack_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - CNT_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Register state, counters, latched request and the registered responses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                 <= IDLE;
         cnt                   <= '0;
         idx_q                 <= '0;
         wdata_q               <= '0;
         target_data_out       <= '0;
         target_data_out_valid <= 1'b0;
         target_ack            <= 1'b0;
         target_err            <= 1'b0;
      end else begin
         state                 <= state_next;
         cnt                   <= cnt_next;
         idx_q                 <= idx_next;
         wdata_q               <= wdata_next;
         target_data_out       <= dout_next;
         target_data_out_valid <= dov_next;
         target_ack            <= ack_next;
         target_err            <= err_next;
      end
   end

endmodule

// File: tb/tb_target_mem_ws.sv
// Bench for target_mem_ws: two instances (zero-latency 8-bit at base 0x0000,
// wait-state 16-bit at base 0x0100) driven by directed and random transactions
// and checked against a transaction-level memory/timing model.
module tb_target_mem_ws;

   logic        clk;
   logic        rst_n;
   logic [15:0] addr [2];
   logic [15:0] din  [2];
   logic [1:0]  addr_valid;
   logic [1:0]  din_valid;
   logic [1:0]  rw;
   logic [7:0]  dout0;
   logic [15:0] dout1;
   logic [1:0]  dov;
   logic [1:0]  ack;
   logic [1:0]  err;
   logic [1:0]  ready;

   int n_assert;
   int n_fail;

   logic [15:0] model [2][256];
   bit          known [2][256];

   target_mem_ws #(
      .DATA_WIDTH         (8),
      .INTERNAL_ADDR_BITS (8),
      .BASE_ADDR          (16'h0000),
      .READ_LATENCY       (0),
      .WRITE_LATENCY      (0),
      .WDATA_TIMEOUT      (15)
   ) dut0 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .target_addr_in        (addr[0]),
      .target_addr_in_valid  (addr_valid[0]),
      .target_data_in        (din[0][7:0]),
      .target_data_in_valid  (din_valid[0]),
      .target_rw             (rw[0]),
      .target_data_out       (dout0),
      .target_data_out_valid (dov[0]),
      .target_ack            (ack[0]),
      .target_err            (err[0]),
      .target_ready          (ready[0])
   );

   target_mem_ws #(
      .DATA_WIDTH         (16),
      .INTERNAL_ADDR_BITS (8),
      .BASE_ADDR          (16'h0100),
      .READ_LATENCY       (3),
      .WRITE_LATENCY      (2),
      .WDATA_TIMEOUT      (15)
   ) dut1 (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .target_addr_in        (addr[1]),
      .target_addr_in_valid  (addr_valid[1]),
      .target_data_in        (din[1]),
      .target_data_in_valid  (din_valid[1]),
      .target_rw             (rw[1]),
      .target_data_out       (dout1),
      .target_data_out_valid (dov[1]),
      .target_ack            (ack[1]),
      .target_err            (err[1]),
      .target_ready          (ready[1])
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed no end of test, required finish before time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   // Configuration of each instance as the model sees it.
   function automatic int rd_lat(input int d);
      return (d == 0) ? 0 : 3;
   endfunction

   function automatic int wr_lat(input int d);
      return (d == 0) ? 0 : 2;
   endfunction

   function automatic int tmo(input int d);
      return 15;
   endfunction

   function automatic logic [15:0] base_of(input int d);
      return (d == 0) ? 16'h0000 : 16'h0100;
   endfunction

   function automatic logic [15:0] mask_of(input int d);
      return (d == 0) ? 16'h00FF : 16'hFFFF;
   endfunction

   function automatic logic [15:0] get_dout(input int d);
      return (d == 0) ? {8'h00, dout0} : dout1;
   endfunction

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed 'h%0h required 'h%0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on instance d, starting and ending at a negedge.
   // data_delay: cycles after address acceptance at which write data arrives
   // (0 = together, > timeout = never in time). interfere: poke extra strobes
   // while the target is busy.
   task automatic apply_txn(input int d, input bit is_wr, input logic [15:0] a,
                            input logic [15:0] data, input int data_delay,
                            input bit interfere, input string tag);
      bit          hit;
      bit          exp_err;
      int          resp;
      int          window;
      int          idx;
      int          ack_first;
      int          ack_cnt;
      int          err_first;
      int          err_cnt;
      int          dov_cnt;
      int          ready_low;
      logic [15:0] ack_data;
      logic [15:0] exp_data;
      bit          data_known;

      hit     = (((a ^ base_of(d)) >> 8) == 16'h0000);
      idx     = int'(a[7:0]);
      exp_err = 1'b0;
      resp    = -1;
      if (hit) begin
         if (!is_wr) resp = rd_lat(d);
         else if (data_delay <= tmo(d)) resp = data_delay + wr_lat(d);
         else begin
            resp    = tmo(d);
            exp_err = 1'b1;
         end
      end
      window     = hit ? resp + 3 : 20;
      exp_data   = model[d][idx];
      data_known = known[d][idx];
      ack_first  = -1;
      err_first  = -1;
      ack_cnt    = 0;
      err_cnt    = 0;
      dov_cnt    = 0;
      ready_low  = 0;
      ack_data   = 'x;

      addr[d]       = a;
      rw[d]         = is_wr;
      din[d]        = data;
      addr_valid[d] = 1'b1;
      din_valid[d]  = is_wr && (data_delay == 0);

      for (int c = 0; c < window; c++) begin
         @(negedge clk);
         addr_valid[d] = 1'b0;
         din_valid[d]  = 1'b0;
         if (ack[d]) begin
            if (ack_first < 0) begin
               ack_first = c;
               ack_data  = get_dout(d);
            end
            ack_cnt++;
         end
         if (err[d]) begin
            if (err_first < 0) err_first = c;
            err_cnt++;
         end
         if (dov[d]) dov_cnt++;
         if (!ready[d]) ready_low++;
         check_output({tag, " pulse_rules"}, 32'({ack[d] & err[d], dov[d] & ~ack[d]}), 32'd0);
         if (is_wr && data_delay > 0 && c + 1 == data_delay) din_valid[d] = 1'b1;
         if (interfere && c == 0) begin
            addr_valid[d] = 1'b1;
            addr[d]       = a ^ 16'h0001;
            rw[d]         = 1'b0;
            din[d]        = ~data;
            din_valid[d]  = 1'b1;
         end
      end
      addr_valid[d] = 1'b0;
      din_valid[d]  = 1'b0;

      check_output({tag, " ack_cycle"}, 32'(ack_first), 32'((hit && !exp_err) ? resp : -1));
      check_output({tag, " ack_count"}, 32'(ack_cnt), 32'((hit && !exp_err) ? 1 : 0));
      check_output({tag, " err_cycle"}, 32'(err_first), 32'(exp_err ? resp : -1));
      check_output({tag, " err_count"}, 32'(err_cnt), 32'(exp_err ? 1 : 0));
      check_output({tag, " busy_cycles"}, 32'(ready_low), 32'(hit ? resp : 0));
      check_output({tag, " dov_count"}, 32'(dov_cnt), 32'((hit && !is_wr) ? 1 : 0));
      if (hit && !is_wr && data_known) begin
         check_output({tag, " rdata"}, 32'(ack_data), 32'(exp_data));
         check_output({tag, " rdata_hold"}, 32'(get_dout(d)), 32'(exp_data));
      end
      if (hit && is_wr && !exp_err) begin
         model[d][idx] = data & mask_of(d);
         known[d][idx] = 1'b1;
      end
   endtask

   // Directed scenarios followed by a random mix, then the summary.
   initial begin
      int          d;
      bit          is_wr;
      int          sel;
      int          dly;
      bit          intf;
      logic [15:0] a;
      logic [15:0] base;
      logic [15:0] data;

      n_assert   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      addr_valid = '0;
      din_valid  = '0;
      rw         = '0;
      for (int i = 0; i < 2; i++) begin
         addr[i] = '0;
         din[i]  = '0;
      end

      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_output("reset ready", 32'(ready[i]), 32'd1);
         check_output("reset ack", 32'(ack[i]), 32'd0);
         check_output("reset err", 32'(err[i]), 32'd0);
         check_output("reset dov", 32'(dov[i]), 32'd0);
         check_output("reset dout", 32'(get_dout(i)), 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] zero-latency write then read");
      apply_txn(0, 1'b1, 16'h0012, 16'h003C, 0, 1'b0, "t1_wr");
      apply_txn(0, 1'b0, 16'h0012, 16'h0000, 0, 1'b0, "t1_rd");

      $display("[TB] wait-state write then read");
      apply_txn(1, 1'b1, 16'h0105, 16'hBEEF, 0, 1'b0, "t2_wr");
      apply_txn(1, 1'b0, 16'h0105, 16'h0000, 0, 1'b0, "t2_rd");

      $display("[TB] late write data, timeout, data on timeout cycle");
      apply_txn(0, 1'b1, 16'h0040, 16'h0077, 4, 1'b0, "t3_late");
      apply_txn(0, 1'b0, 16'h0040, 16'h0000, 0, 1'b0, "t3_late_rd");
      apply_txn(0, 1'b1, 16'h0041, 16'h005A, 0, 1'b0, "t3_pre");
      apply_txn(0, 1'b1, 16'h0041, 16'h00EE, 99, 1'b0, "t3_tmo");
      apply_txn(0, 1'b0, 16'h0041, 16'h0000, 0, 1'b0, "t3_tmo_rd");
      apply_txn(0, 1'b1, 16'h0042, 16'h0024, 15, 1'b0, "t3_edge");
      apply_txn(0, 1'b0, 16'h0042, 16'h0000, 0, 1'b0, "t3_edge_rd");
      apply_txn(1, 1'b1, 16'h0143, 16'hA5C3, 7, 1'b0, "t3_ws_late");
      apply_txn(1, 1'b0, 16'h0143, 16'h0000, 0, 1'b0, "t3_ws_late_rd");

      $display("[TB] window decode");
      apply_txn(1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, "t4_miss");
      apply_txn(1, 1'b1, 16'h0005, 16'h1111, 0, 1'b0, "t4_miss_wr");
      apply_txn(1, 1'b0, 16'h0105, 16'h0000, 0, 1'b0, "t4_hit");
      apply_txn(0, 1'b0, 16'h0112, 16'h0000, 0, 1'b0, "t4_miss0");

      $display("[TB] strobes while busy are ignored");
      apply_txn(1, 1'b0, 16'h0105, 16'h0000, 0, 1'b1, "t5_rdbusy");
      apply_txn(1, 1'b1, 16'h0106, 16'h1234, 0, 1'b1, "t5_wrbusy");
      apply_txn(1, 1'b0, 16'h0106, 16'h0000, 0, 1'b0, "t5_wrbusy_rd");

      $display("[TB] back-to-back zero-latency reads");
      for (int i = 0; i < 4; i++) begin
         apply_txn(0, 1'b1, 16'h0010 + 16'(i), 16'h00A0 + 16'(i * 7), 0, 1'b0, "t5_fill");
      end
      for (int i = 0; i < 4; i++) begin
         addr[0]       = 16'h0010 + 16'(i);
         rw[0]         = 1'b0;
         addr_valid[0] = 1'b1;
         @(negedge clk);
         check_output("t5_b2b ack", 32'(ack[0]), 32'd1);
         check_output("t5_b2b data", 32'(get_dout(0)), 32'(model[0][16 + i]));
      end
      addr_valid[0] = 1'b0;
      @(negedge clk);
      check_output("t5_b2b idle ack", 32'(ack[0]), 32'd0);

      $display("[TB] write data without address strobe is ignored");
      addr[0]      = 16'h0010;
      rw[0]        = 1'b1;
      din[0]       = 16'h00FF;
      din_valid[0] = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("stray_data ack", 32'(ack[0]), 32'd0);
      end
      din_valid[0] = 1'b0;
      apply_txn(0, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, "stray_data_rd");

      $display("[TB] reset during write wait");
      apply_txn(1, 1'b1, 16'h0107, 16'h0011, 0, 1'b0, "t6_pre");
      addr[1]       = 16'h0107;
      rw[1]         = 1'b1;
      din[1]        = 16'h0099;
      addr_valid[1] = 1'b1;
      din_valid[1]  = 1'b1;
      @(negedge clk);
      addr_valid[1] = 1'b0;
      din_valid[1]  = 1'b0;
      check_output("t6 busy", 32'(ready[1]), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("t6 ready", 32'(ready[1]), 32'd1);
      check_output("t6 ack", 32'(ack[1]), 32'd0);
      check_output("t6 dov", 32'(dov[1]), 32'd0);
      check_output("t6 dout", 32'(get_dout(1)), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_output("t6 post ack", 32'(ack[1]), 32'd0);
      end
      apply_txn(1, 1'b0, 16'h0107, 16'h0000, 0, 1'b0, "t6_rd");

      $display("[TB] random traffic");
      for (int i = 0; i < 60; i++) begin
         d     = i % 2;
         base  = base_of(d);
         is_wr = 1'($urandom_range(0, 1));
         sel   = int'($urandom_range(0, 9));
         a     = (sel == 0) ? ((base ^ 16'h0100) | 16'($urandom_range(0, 15)))
                            : (base | 16'($urandom_range(0, 15)));
         data  = 16'($urandom);
         dly   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 17));
         intf  = (d == 1) && (dly == 0) && ($urandom_range(0, 2) == 0);
         apply_txn(d, is_wr, a, data, dly, intf, $sformatf("rnd%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
